// File: rtl/mdu_ctrl.sv
// RV64M multiply/divide sequencer: radix-2 shift-add multiplier and restoring
// divider behind valid/ready handshakes on both sides.
module mdu_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             inst_32bit,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_64   = 64'h8000_0000_0000_0000;
  localparam logic [WIDTH-1:0] MIN_32   = 64'hFFFF_FFFF_8000_0000;

  state_e           state_q;
  logic [4:0]       op_q;
  logic             w_q;
  logic [6:0]       cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;

  logic             op_ok;
  logic             is_signed;
  logic             div_zero;
  logic             ovf;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] s1x;
  logic [WIDTH-1:0] s2x;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] div_init;

  // Operand preparation and special-case detection for the accept cycle
  always_comb begin
    case (op)
      5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000: op_ok = 1'b1;
      default:                                          op_ok = 1'b0;
    endcase
    is_signed = op[0] | op[1] | op[3];
    if (inst_32bit) begin
      s1x = is_signed ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]};
      s2x = is_signed ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]};
    end else begin
      s1x = src1;
      s2x = src2;
    end
    div_zero = (s2x == {WIDTH{1'b0}});
    ovf      = is_signed && (s1x == (inst_32bit ? MIN_32 : MIN_64)) && (s2x == ALL_ONES);
    neg1     = is_signed & s1x[WIDTH-1];
    neg2     = is_signed & s2x[WIDTH-1];
    mag1     = neg1 ? (~s1x + 64'd1) : s1x;
    mag2     = neg2 ? (~s2x + 64'd1) : s2x;
    // W dividends are pre-shifted so the MSB-first divider starts at bit 31
    div_init = inst_32bit ? {mag1[31:0], 32'd0} : mag1;
  end

  logic [6:0]       cnt_d;
  logic [6:0]       n_steps;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] div_r_d;
  logic [WIDTH-1:0] div_a_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] raw_fix;
  logic [WIDTH-1:0] fix_d;

  // One multiply/divide iteration and the sign/width fix-up of the final value
  always_comb begin
    cnt_d     = cnt_q + 7'd1;
    n_steps   = w_q ? 7'd32 : 7'd64;
    mul_acc_d = r_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
    rem_shift = {r_q, a_q[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, b_q});
    div_r_d   = fits ? (rem_shift[WIDTH-1:0] - b_q) : rem_shift[WIDTH-1:0];
    div_a_d   = {a_q[WIDTH-2:0], fits};
    quo_fix   = neg_q_q ? (~a_q + 64'd1) : a_q;
    rem_fix   = neg_r_q ? (~r_q + 64'd1) : r_q;
    case (op_q)
      5'b00001:           raw_fix = r_q;
      5'b00010, 5'b00100: raw_fix = quo_fix;
      5'b01000, 5'b10000: raw_fix = rem_fix;
      default:            raw_fix = {WIDTH{1'b0}};
    endcase
    if (w_q) begin
      fix_d = {{32{raw_fix[31]}}, raw_fix[31:0]};
    end else begin
      fix_d = raw_fix;
    end
  end

  // Sequencer state, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      w_q         <= 1'b0;
      cnt_q       <= 7'd0;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= op_ok ? op : 5'd0;
            w_q     <= inst_32bit;
            cnt_q   <= 7'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            if (!op_ok) begin
              state_q <= S_FIX;
            end else if (op[0]) begin
              a_q     <= s1x;
              b_q     <= s2x;
              r_q     <= {WIDTH{1'b0}};
              state_q <= S_MUL;
            end else if (div_zero) begin
              a_q     <= ALL_ONES;
              r_q     <= s1x;
              state_q <= S_FIX;
            end else if (ovf) begin
              a_q     <= s1x;
              r_q     <= {WIDTH{1'b0}};
              state_q <= S_FIX;
            end else begin
              a_q     <= div_init;
              b_q     <= mag2;
              r_q     <= {WIDTH{1'b0}};
              neg_q_q <= neg1 ^ neg2;
              neg_r_q <= neg1;
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          r_q   <= mul_acc_d;
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q <= cnt_d;
          if (cnt_d == n_steps) state_q <= S_FIX;
        end
        S_DIV: begin
          r_q   <= div_r_d;
          a_q   <= div_a_d;
          cnt_q <= cnt_d;
          if (cnt_d == n_steps) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q    <= fix_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: results, latencies, handshake hold, flush and reset.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic        inst_32bit;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_total;
  int n_bad;

  localparam logic [4:0] OP_MUL  = 5'b00001;
  localparam logic [4:0] OP_DIV  = 5'b00010;
  localparam logic [4:0] OP_DIVU = 5'b00100;
  localparam logic [4:0] OP_REM  = 5'b01000;
  localparam logic [4:0] OP_REMU = 5'b10000;

  mdu_ctrl #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .inst_32bit(inst_32bit),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [4:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    op         = o;
    inst_32bit = w;
    src1       = a;
    src2       = b;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_r, input int exp_lat, input bit hold);
    int cyc;
    int busy_low;
    int hold_bad;
    start_op(o, w, a, b);
    cyc      = 1;
    busy_low = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_low++;
      step();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_busy"}, 64'(busy_low), 64'd0);
    if (hold) begin
      hold_bad = 0;
      for (int i = 0; i < 5; i++) begin
        step();
        if (result !== exp_r || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
      end
      chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    int seen;
    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    op         = 5'd0;
    inst_32bit = 1'b0;
    src1       = 64'd0;
    src2       = 64'd0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    chk("reset_flags", {60'd0, out_valid, busy, in_ready, 1'b0}, 64'd2);
    chk("reset_result", result, 64'd0);
    rst = 1'b1;

    run_op("mul", OP_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
    run_op("mulw", OP_MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0);
    run_op("div0", OP_DIV, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
    run_op("remu0", OP_REMU, 1'b0, 64'd7, 64'd0, 64'd7, 2, 1'b0);
    run_op("div_ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 2, 1'b0);
    run_op("rem_ovf", OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 2, 1'b0);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 2, 1'b0);
    run_op("div_neg", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0);
    run_op("rem_neg", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0);
    run_op("divuw", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
    run_op("remw_neg", OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0);
    run_op("divu_big", OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66, 1'b0);
    run_op("rem_hold", OP_REM, 1'b0, 64'd100, 64'd7, 64'd2, 66, 1'b1);
    run_op("bad_op", 5'b00011, 1'b0, 64'd5, 64'd5, 64'd0, 2, 1'b0);

    // Flush during iteration 10 must drop the operation entirely
    start_op(OP_DIV, 1'b0, 64'd100, 64'd7);
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_state", {61'd0, in_ready, busy, out_valid}, 64'd4);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run_op("mul_after_flush", OP_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 66, 1'b0);

    start_op(OP_DIV, 1'b0, 64'd1000, 64'd3);
    for (int i = 1; i < 20; i++) step();
    rst = 1'b0;
    step();
    chk("midrst_flags", {60'd0, out_valid, busy, in_ready, 1'b0}, 64'd2);
    chk("midrst_result", result, 64'd0);
    rst = 1'b1;
    run_op("div_after_rst", OP_DIV, 1'b0, 64'd1000, 64'd3, 64'd333, 66, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide operations that the decoder flags on alu_op[16:12]: MUL/MULW, DIV/DIVW, DIVU/DIVUW, REM/REMW, REMU/REMUW.
- Owns a radix-2 shift-add multiplier and a restoring divider, plus its operand and result registers.
- Sits beside the single-cycle ALU in the execute stage.
- Talks to the execute stage through valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 64, datapath width. Only 64 is supported. 32-bit variants use bits [31:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  controller can accept a request. High only in IDLE.
- op  in  5  one-hot, same order as alu_op[16:12]: [0] mul, [1] div, [2] divu, [3] rem, [4] remu.
- inst_32bit  in  1  W-variant select.
- src1  in  WIDTH  dividend / multiplicand.
- src2  in  WIDTH  divisor / multiplier.
- flush  in  1  abandon the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  final value.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - out_valid=0, result=0, busy=0, in_ready=1.
  - All internal registers are cleared.
  - A reset in the middle of an operation discards that operation.
- States and transitions:
  - IDLE -> MUL or DIV on accept.
  - IDLE -> FIX directly on accept when the operation is a divide special case (see below).
  - MUL/DIV -> FIX after the step counter reaches N.
  - FIX -> DONE.
  - DONE -> IDLE when out_valid && out_ready.
- Accept: happens when in_valid && in_ready && !flush. In that cycle the block latches op, inst_32bit and the prepared operands.
- Operand preparation, 32-bit ops:
  - Signed ops (mul, div, rem) sign-extend bit 31.
  - Unsigned ops (divu, remu) zero-extend bit 31.
  - Upstream zero-extends W operands, so this step is mandatory.
- Step count N: 64 for 64-bit ops, 32 for W ops. One iteration per cycle, tracked by a 7-bit counter.
- Multiply:
  - Each iteration: if multiplier bit 0 is 1, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
  - Keep the low WIDTH bits only.
  - The result is sign-agnostic because MUL returns the low half.
- Divide:
  - Divide magnitudes with a restoring divider that produces one quotient bit per iteration.
  - FIX applies the signs (signed ops only):
    - quotient is negated if sign(src1) != sign(src2).
    - remainder takes the sign of src1.
- Special cases (detected at accept; skip the iterations and go straight to FIX):
  - Divisor == 0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most negative value and divisor = -1, at the selected width): quotient = dividend, remainder = 0.
- W ops: result = sign-extension of the 32-bit result bit 31. This applies to divuw and remuw too.
- Invalid op (op zero or not one-hot at accept): go straight to FIX, result = 0.
- Latency, counted from the accept cycle as cycle 0:
  - Iterations run in cycles 1..N.
  - FIX runs in cycle N+1.
  - out_valid rises at cycle N+2: 66 for 64-bit ops, 34 for W ops.
  - Special and invalid ops: out_valid at cycle 2.
- Output:
  - result is registered and is written only in FIX.
  - out_valid is held with result stable until out_ready is seen.
  - The cycle after the handshake: IDLE, in_ready=1. No back-to-back accept in DONE.
  - result keeps its last value after the handshake.
- Flush:
  - Synchronous. Takes priority over in_valid and over every state.
  - Next cycle: IDLE, out_valid=0. No result is delivered and the counter is cleared.
  - Flush in DONE drops the pending result.
- in_valid while not in IDLE is ignored. The producer must hold its request until in_ready is high.

Test Plan:
- mul, src1=0xFFFFFFFFFFFFFFFF, src2=3 -> result 0xFFFFFFFFFFFFFFFD; out_valid exactly 66 cycles after accept; busy high throughout.
- mul with inst_32bit=1, src1=0x000000007FFFFFFF, src2=2 -> 0xFFFFFFFFFFFFFFFE at cycle 34.
- div, src1=7, src2=0 -> 0xFFFFFFFFFFFFFFFF; remu, src1=7, src2=0 -> 7. Both at cycle 2.
- Overflow cases, all at cycle 2:
  - div, 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000.
  - rem, same operands -> 0.
  - div with inst_32bit=1, 0x0000000080000000 / 0x00000000FFFFFFFF -> 0xFFFFFFFF80000000.
- Sign and W-extension cases:
  - div, -7 / 2 -> 0xFFFFFFFFFFFFFFFD.
  - rem, -7 / 2 -> 0xFFFFFFFFFFFFFFFF.
  - divu with inst_32bit=1, 0x00000000FFFFFFFF / 1 -> 0xFFFFFFFFFFFFFFFF.
- Handshake and abort:
  - Hold out_ready low for 5 cycles -> result and out_valid stay stable; in_ready stays 0.
  - Flush at iteration 10 -> out_valid never rises; in_ready=1 on the next cycle. A following mul 3*4 -> 12.
  - rst=0 mid-divide -> all outputs at their reset values on the next cycle.
